// File: rtl/ball_engine.sv
// ball_engine -- multi-ball bouncing game engine with bar collision and scoring.
//
// Each ball moves by a fixed speed on every movement tick, bounces off the
// playfield walls, and ends the game when it overlaps the bar box. A tick is
// TICK_DIV clock cycles spent in RUN. The balls are then updated one per cycle
// in UPDATE. The score advances once every SCORE_TICKS movement ticks.
//
// Optional feature: define BALL_ENGINE_SPEEDUP_EN to add 1 to both axis speeds
// (saturating at MAX_SPD) on every score increment. Without it the speeds are
// the constants SPD_X/SPD_Y.
//
// Ports:
//   CLOCK_50                   sole clock, rising edge
//   reset                      synchronous active-high reset, highest priority
//   start                      one-cycle pulse; (re)starts a game from IDLE/OVER
//   bar_leftLimit/rightLimit   bar box x range, right exclusive
//   bar_topLimit/bottomLimit   bar box y range, bottom exclusive
//   ball_x, ball_y             left/top edge of ball i at [i*POS_W +: POS_W]
//   running                    high in RUN or UPDATE
//   game_over                  high in OVER
//   currentScore, highScore    score of current game, best score since reset
module ball_engine #(
  parameter int NUM_BALLS   = 2,
  parameter int POS_W       = 10,
  parameter int SCR_W       = 640,
  parameter int SCR_H       = 480,
  parameter int BALL_SIZE   = 16,
  parameter int TICK_DIV    = 50000,
  parameter int INIT_X      = 240,
  parameter int INIT_Y      = 90,
  parameter int SPD_X       = 2,
  parameter int SPD_Y       = 4,
  parameter int MAX_SPD     = 8,
  parameter int SCORE_W     = 18,
  parameter int SCORE_TICKS = 1000
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       start,
  input  logic [POS_W-1:0]           bar_leftLimit,
  input  logic [POS_W-1:0]           bar_rightLimit,
  input  logic [POS_W-1:0]           bar_topLimit,
  input  logic [POS_W-1:0]           bar_bottomLimit,
  output logic [NUM_BALLS*POS_W-1:0] ball_x,
  output logic [NUM_BALLS*POS_W-1:0] ball_y,
  output logic                       running,
  output logic                       game_over,
  output logic [SCORE_W-1:0]         currentScore,
  output logic [SCORE_W-1:0]         highScore
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCORE_TICKS > 1) ? $clog2(SCORE_TICKS) : 1;
  localparam int IW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
  localparam int EW = POS_W + 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCORE_LAST = SW'(SCORE_TICKS - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_BALLS - 1);
  localparam logic [EW-1:0] LIM_X      = EW'(SCR_W - BALL_SIZE);
  localparam logic [EW-1:0] LIM_Y      = EW'(SCR_H - BALL_SIZE);

  typedef enum logic [1:0] {IDLE, RUN, UPDATE, OVER} state_t;

  state_t               state_reg;
  logic [IW-1:0]        idx_reg;
  logic [TW-1:0]        tick_cnt_reg;
  logic [SW-1:0]        score_cnt_reg;
  logic [SCORE_W-1:0]   score_reg;
  logic [SCORE_W-1:0]   high_reg;
  logic                 hit_reg;
  logic                 running_reg;
  logic                 game_over_reg;

  logic [POS_W-1:0]     x_reg [NUM_BALLS];
  logic [POS_W-1:0]     y_reg [NUM_BALLS];
  logic [NUM_BALLS-1:0] x_dir_reg;
  logic [NUM_BALLS-1:0] y_dir_reg;

  logic [POS_W-1:0]     nx [NUM_BALLS];
  logic [POS_W-1:0]     ny [NUM_BALLS];
  logic [NUM_BALLS-1:0] ndx;
  logic [NUM_BALLS-1:0] ndy;
  logic [NUM_BALLS-1:0] hit_b;
  logic                 hit_cur;

  logic [POS_W-1:0]     spd_x;
  logic [POS_W-1:0]     spd_y;

  logic                 start_load;
  logic                 load_init;

  assign start_load = start && (state_reg == IDLE || state_reg == OVER);
  assign load_init  = reset || start_load;

  // One axis step with clamping to [0, lim]. The subtract case is tested
  // against the speed directly so an underflow never wraps into a large value.
  function automatic logic [EW-1:0] axis_next(
    input logic [POS_W-1:0] pos,
    input logic [POS_W-1:0] spd,
    input logic             dir,
    input logic [EW-1:0]    lim
  );
    logic [EW-1:0] sum;
    if (dir) sum = {1'b0, pos} + {1'b0, spd};
    else     sum = {1'b0, pos} - {1'b0, spd};
    if (!dir && (spd > pos)) axis_next = '0;
    else if (sum > lim)      axis_next = lim;
    else                     axis_next = sum;
  endfunction

`ifdef BALL_ENGINE_SPEEDUP_EN
  logic [POS_W-1:0] spd_x_reg;
  logic [POS_W-1:0] spd_y_reg;
  logic             score_inc;

  // Same condition under which the FSM bumps the score.
  assign score_inc = (state_reg == RUN) && (tick_cnt_reg == TICK_LAST) &&
                     (score_cnt_reg == SCORE_LAST) && (score_reg != '1);

  always_ff @(posedge CLOCK_50) begin
    if (load_init) begin
      spd_x_reg <= POS_W'(SPD_X);
      spd_y_reg <= POS_W'(SPD_Y);
    end else if (score_inc) begin
      if (spd_x_reg < POS_W'(MAX_SPD)) spd_x_reg <= spd_x_reg + 1'b1;
      if (spd_y_reg < POS_W'(MAX_SPD)) spd_y_reg <= spd_y_reg + 1'b1;
    end
  end

  assign spd_x = spd_x_reg;
  assign spd_y = spd_y_reg;
`else
  assign spd_x = POS_W'(SPD_X);
  assign spd_y = POS_W'(SPD_Y);
`endif

  // Per-ball next position, bounce direction and bar overlap.
  generate
    for (genvar gi = 0; gi < NUM_BALLS; gi++) begin : g_ball
      logic [EW-1:0] nx_e;
      logic [EW-1:0] ny_e;

      assign nx_e = axis_next(x_reg[gi], spd_x, x_dir_reg[gi], LIM_X);
      assign ny_e = axis_next(y_reg[gi], spd_y, y_dir_reg[gi], LIM_Y);

      // Limits are below 2**POS_W, so the top bit of the clamped value is zero.
      assign nx[gi]  = nx_e[POS_W-1:0];
      assign ny[gi]  = ny_e[POS_W-1:0];
      assign ndx[gi] = (nx_e == '0 || nx_e == LIM_X) ? ~x_dir_reg[gi] : x_dir_reg[gi];
      assign ndy[gi] = (ny_e == '0 || ny_e == LIM_Y) ? ~y_dir_reg[gi] : y_dir_reg[gi];

      assign hit_b[gi] = (nx_e < {1'b0, bar_rightLimit}) &&
                         ((nx_e + EW'(BALL_SIZE)) > {1'b0, bar_leftLimit}) &&
                         (ny_e < {1'b0, bar_bottomLimit}) &&
                         ((ny_e + EW'(BALL_SIZE)) > {1'b0, bar_topLimit});

      assign ball_x[gi*POS_W +: POS_W] = x_reg[gi];
      assign ball_y[gi*POS_W +: POS_W] = y_reg[gi];
    end
  endgenerate

  always_comb begin
    hit_cur = 1'b0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      if (idx_reg == IW'(i)) hit_cur = hit_b[i];
    end
  end

  // Ball state: loaded on reset/start, otherwise written only in its own
  // UPDATE cycle.
  always_ff @(posedge CLOCK_50) begin
    for (int i = 0; i < NUM_BALLS; i++) begin
      if (load_init) begin
        x_reg[i]     <= POS_W'(INIT_X + 2 * i * BALL_SIZE);
        y_reg[i]     <= POS_W'(INIT_Y);
        x_dir_reg[i] <= (i % 2 == 0);
        y_dir_reg[i] <= 1'b1;
      end else if (state_reg == UPDATE && idx_reg == IW'(i)) begin
        x_reg[i]     <= nx[i];
        y_reg[i]     <= ny[i];
        x_dir_reg[i] <= ndx[i];
        y_dir_reg[i] <= ndy[i];
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      tick_cnt_reg  <= '0;
      score_cnt_reg <= '0;
      score_reg     <= '0;
      high_reg      <= '0;
      hit_reg       <= 1'b0;
      running_reg   <= 1'b0;
      game_over_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, OVER: begin
          if (start) begin
            state_reg     <= RUN;
            idx_reg       <= '0;
            tick_cnt_reg  <= '0;
            score_cnt_reg <= '0;
            score_reg     <= '0;
            hit_reg       <= 1'b0;
            running_reg   <= 1'b1;
            game_over_reg <= 1'b0;
          end
        end
        RUN: begin
          if (tick_cnt_reg == TICK_LAST) begin
            tick_cnt_reg <= '0;
            state_reg    <= UPDATE;
            idx_reg      <= '0;
            hit_reg      <= 1'b0;
            if (score_cnt_reg == SCORE_LAST) begin
              score_cnt_reg <= '0;
              if (score_reg != '1) score_reg <= score_reg + 1'b1;
            end else begin
              score_cnt_reg <= score_cnt_reg + 1'b1;
            end
          end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
          end
        end
        UPDATE: begin
          if (idx_reg == IDX_LAST) begin
            // Every ball has moved in this pass; any overlap ends the game.
            if (hit_reg || hit_cur) begin
              state_reg     <= OVER;
              running_reg   <= 1'b0;
              game_over_reg <= 1'b1;
              if (score_reg > high_reg) high_reg <= score_reg;
            end else begin
              state_reg <= RUN;
            end
          end else begin
            idx_reg <= idx_reg + 1'b1;
            hit_reg <= hit_reg || hit_cur;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign running      = running_reg;
  assign game_over    = game_over_reg;
  assign currentScore = score_reg;
  assign highScore    = high_reg;

endmodule

// File: tb/tb_ball_engine.sv
// Self-checking bench for ball_engine with a small tick divider and a narrow
// score so that saturation, wall bounces and game-over are reached quickly.
module tb_ball_engine;
  localparam int NB = 2, PW = 10, TD = 4, ST = 3, SW = 3;
  localparam int BS = 16, LX = 640 - 16, LY = 480 - 16, SMAX = 7, PASS = TD + NB;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [PW-1:0] bar_l, bar_r, bar_t, bar_b;
  logic [NB*PW-1:0] ball_x, ball_y;
  logic running, game_over;
  logic [SW-1:0] cur, high;

  int errors = 0, checks = 0;

  // Reference model state
  int mx[NB], my[NB];
  bit mdx[NB], mdy[NB];
  int mspx, mspy, mscore, mscnt, mhigh;
  bit mover;

  ball_engine #(.NUM_BALLS(NB), .POS_W(PW), .TICK_DIV(TD), .SCORE_W(SW),
                .SCORE_TICKS(ST)) dut (
    .CLOCK_50(clk), .reset(reset), .start(start),
    .bar_leftLimit(bar_l), .bar_rightLimit(bar_r),
    .bar_topLimit(bar_t), .bar_bottomLimit(bar_b),
    .ball_x(ball_x), .ball_y(ball_y), .running(running), .game_over(game_over),
    .currentScore(cur), .highScore(high));

  always #5 clk = ~clk;

  function automatic int bx(int i); return int'(ball_x[i*PW +: PW]); endfunction
  function automatic int by(int i); return int'(ball_y[i*PW +: PW]); endfunction

  function automatic void model_start();
    for (int i = 0; i < NB; i++) begin
      mx[i] = 240 + 2 * i * BS; my[i] = 90; mdx[i] = (i % 2 == 0); mdy[i] = 1'b1;
    end
    mscore = 0; mscnt = 0; mspx = 2; mspy = 4; mover = 1'b0;
  endfunction

  function automatic int clamp(int v, int lim);
    if (v < 0) return 0;
    if (v > lim) return lim;
    return v;
  endfunction

  // One movement tick: score first, then every ball moves, then game-over.
  function automatic void model_tick();
    bit hit = 1'b0;
    int nx, ny;
    mscnt++;
    if (mscnt == ST) begin
      mscnt = 0;
      if (mscore < SMAX) begin
        mscore++;
`ifdef BALL_ENGINE_SPEEDUP_EN
        if (mspx < 8) mspx++;
        if (mspy < 8) mspy++;
`endif
      end
    end
    for (int i = 0; i < NB; i++) begin
      nx = clamp(mdx[i] ? mx[i] + mspx : mx[i] - mspx, LX);
      ny = clamp(mdy[i] ? my[i] + mspy : my[i] - mspy, LY);
      if (nx == 0 || nx == LX) mdx[i] = !mdx[i];
      if (ny == 0 || ny == LY) mdy[i] = !mdy[i];
      mx[i] = nx; my[i] = ny;
      if (nx < int'(bar_r) && nx + BS > int'(bar_l) && ny < int'(bar_b) && ny + BS > int'(bar_t))
        hit = 1'b1;
    end
    if (hit) begin
      mover = 1'b1;
      if (mscore > mhigh) mhigh = mscore;
    end
  endfunction

  task automatic test_reset();
    bar_l = 10'd1000; bar_r = 10'd1010; bar_t = 10'd1000; bar_b = 10'd1010;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_start(); mhigh = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      checks++; if (bx(i) !== mx[i]) begin errors++; $display("FAIL reset_x%0d got %0d want %0d", i, bx(i), mx[i]); end
      checks++; if (by(i) !== my[i]) begin errors++; $display("FAIL reset_y%0d got %0d want %0d", i, by(i), my[i]); end
    end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", running); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over got %b want 0", game_over); end
    checks++; if (cur !== 3'd0) begin errors++; $display("FAIL reset_score got %0d want 0", cur); end
    checks++; if (high !== 3'd0) begin errors++; $display("FAIL reset_high got %0d want 0", high); end
  endtask

  task automatic test_first_pass();
    model_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running got %b want 1", running); end
    repeat (TD) @(negedge clk);
    checks++; if (bx(0) !== 240) begin errors++; $display("FAIL pre_update_x0 got %0d want 240", bx(0)); end
    @(negedge clk);
    model_tick();
    // Ball 0 has moved, ball 1 still waits for its own cycle.
    checks++; if (bx(0) !== 242 || by(0) !== 94) begin errors++; $display("FAIL pass1_ball0 got (%0d,%0d) want (242,94)", bx(0), by(0)); end
    checks++; if (bx(1) !== 272 || by(1) !== 90) begin errors++; $display("FAIL pass1_ball1_hold got (%0d,%0d) want (272,90)", bx(1), by(1)); end
    @(negedge clk);
    checks++; if (bx(1) !== mx[1] || by(1) !== my[1]) begin errors++; $display("FAIL pass1_ball1 got (%0d,%0d) want (%0d,%0d)", bx(1), by(1), mx[1], my[1]); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL pass1_running got %b want 1", running); end
  endtask

  task automatic test_start_ignored();
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (PASS - 1) @(negedge clk);
    model_tick();
    for (int i = 0; i < NB; i++) begin
      checks++; if (bx(i) !== mx[i] || by(i) !== my[i]) begin errors++; $display("FAIL start_in_run ball%0d got (%0d,%0d) want (%0d,%0d)", i, bx(i), by(i), mx[i], my[i]); end
    end
    checks++; if (cur !== SW'(mscore)) begin errors++; $display("FAIL start_in_run_score got %0d want %0d", cur, mscore); end
  endtask

  task automatic test_games();
    for (int g = 0; g < 5; g++) begin
      int t = 0;
      case (g)
        0: begin bar_l = 10'd1000; bar_r = 10'd1010; bar_t = 10'd1000; bar_b = 10'd1010; end
        1: begin bar_l = 10'd240; bar_r = 10'd400; bar_t = 10'd300; bar_b = 10'd320; end
        2: begin bar_l = 10'd240; bar_r = 10'd400; bar_t = 10'd168; bar_b = 10'd188; end
        default: begin
          bar_l = PW'($urandom_range(0, 600));
          bar_r = PW'(clamp(int'(bar_l) + int'($urandom_range(8, 80)), 640));
          bar_t = PW'($urandom_range(0, 460));
          bar_b = PW'(clamp(int'(bar_t) + int'($urandom_range(4, 40)), 480));
        end
      endcase
      while (!mover) begin
        // A field-wide bar guarantees the game ends after the bound.
        if (t == 60) begin bar_l = '0; bar_r = 10'd640; bar_t = '0; bar_b = 10'd480; end
        repeat (PASS) @(negedge clk);
        model_tick(); t++;
        for (int i = 0; i < NB; i++) begin
          checks++; if (bx(i) !== mx[i] || by(i) !== my[i]) begin errors++; $display("FAIL game%0d tick%0d ball%0d got (%0d,%0d) want (%0d,%0d)", g, t, i, bx(i), by(i), mx[i], my[i]); end
        end
        checks++; if (cur !== SW'(mscore)) begin errors++; $display("FAIL game%0d tick%0d score got %0d want %0d", g, t, cur, mscore); end
        checks++; if (game_over !== mover || running !== !mover) begin errors++; $display("FAIL game%0d tick%0d flags got go=%b run=%b want go=%b", g, t, game_over, running, mover); end
        checks++; if (high !== SW'(mhigh)) begin errors++; $display("FAIL game%0d tick%0d high got %0d want %0d", g, t, high, mhigh); end
      end
      $display("game %0d over after %0d ticks score=%0d high=%0d", g, t, mscore, mhigh);
      if (g < 4) begin
        repeat ($urandom_range(1, 6)) @(negedge clk);
        checks++; if (bx(0) !== mx[0] || game_over !== 1'b1) begin errors++; $display("FAIL game%0d over_hold x0 got %0d want %0d go=%b", g, bx(0), mx[0], game_over); end
        model_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
        checks++; if (cur !== 3'd0 || high !== SW'(mhigh)) begin errors++; $display("FAIL game%0d restart scores got %0d/%0d want 0/%0d", g, cur, high, mhigh); end
        checks++; if (bx(1) !== mx[1] || by(1) !== my[1] || running !== 1'b1) begin errors++; $display("FAIL game%0d restart ball1 got (%0d,%0d) run=%b", g, bx(1), by(1), running); end
      end
    end
  endtask

  task automatic test_over_frozen();
    repeat (20) @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      checks++; if (bx(i) !== mx[i] || by(i) !== my[i]) begin errors++; $display("FAIL frozen ball%0d got (%0d,%0d) want (%0d,%0d)", i, bx(i), by(i), mx[i], my[i]); end
    end
    checks++; if (cur !== SW'(mscore) || high !== SW'(mhigh) || game_over !== 1'b1) begin errors++; $display("FAIL frozen scores got %0d/%0d go=%b want %0d/%0d", cur, high, game_over, mscore, mhigh); end
  endtask

  task automatic test_restart();
    bar_l = 10'd1000; bar_r = 10'd1010; bar_t = 10'd1000; bar_b = 10'd1010;
    model_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int i = 0; i < NB; i++) begin
      checks++; if (bx(i) !== mx[i] || by(i) !== my[i]) begin errors++; $display("FAIL restart ball%0d got (%0d,%0d) want (%0d,%0d)", i, bx(i), by(i), mx[i], my[i]); end
    end
    checks++; if (cur !== 3'd0) begin errors++; $display("FAIL restart_score got %0d want 0", cur); end
    checks++; if (high !== SW'(mhigh)) begin errors++; $display("FAIL restart_high got %0d want %0d", high, mhigh); end
    repeat (PASS) @(negedge clk);
    model_tick();
    checks++; if (bx(0) !== mx[0] || by(0) !== my[0]) begin errors++; $display("FAIL restart_pass got (%0d,%0d) want (%0d,%0d)", bx(0), by(0), mx[0], my[0]); end
  endtask

  task automatic test_reset_mid_update();
    // Five edges from a pass boundary leave the FSM in UPDATE at index 1.
    repeat (TD + 1) @(negedge clk);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    model_start(); mhigh = 0;
    for (int i = 0; i < NB; i++) begin
      checks++; if (bx(i) !== mx[i] || by(i) !== my[i]) begin errors++; $display("FAIL midreset ball%0d got (%0d,%0d) want (%0d,%0d)", i, bx(i), by(i), mx[i], my[i]); end
    end
    checks++; if (running !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL midreset flags got run=%b go=%b want 0/0", running, game_over); end
    checks++; if (cur !== 3'd0 || high !== 3'd0) begin errors++; $display("FAIL midreset scores got %0d/%0d want 0/0", cur, high); end
    repeat (10) @(negedge clk);
    checks++; if (running !== 1'b0 || bx(0) !== mx[0]) begin errors++; $display("FAIL midreset_idle got run=%b x0=%0d want 0/%0d", running, bx(0), mx[0]); end
  endtask

  initial begin
    test_reset();
    test_first_pass();
    test_start_ignored();
    test_games();
    test_over_frozen();
    test_restart();
    test_reset_mid_update();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ball_engine.md
BALL_ENGINE -- requirements
Module: ball_engine

Interface
REQ-001 Parameter NUM_BALLS, default 2: number of independent balls (1..4).
REQ-002 Parameter POS_W, default 10: coordinate width.
REQ-003 Parameter SCR_W, default 640; SCR_H, default 480: playfield size in pixels.
REQ-004 Parameter BALL_SIZE, default 16: ball edge length in pixels.
REQ-005 Parameter TICK_DIV, default 50000: clock cycles per movement tick.
REQ-006 Parameter INIT_X, default 240; INIT_Y, default 90: left/top edge of ball 0 at start.
REQ-007 Parameter SPD_X, default 2; SPD_Y, default 4; MAX_SPD, default 8: speeds in pixels per tick.
REQ-008 Parameter SCORE_W, default 18; SCORE_TICKS, default 1000: score width; ticks per point.
REQ-009 CLOCK_50  in  1  sole clock, rising edge.
REQ-010 reset  in  1  synchronous, active-high.
REQ-011 start  in  1  one-cycle pulse; starts or restarts a game.
REQ-012 bar_leftLimit, bar_rightLimit, bar_topLimit, bar_bottomLimit  in  POS_W each  bar box, right/bottom exclusive.
REQ-013 ball_x, ball_y  out  NUM_BALLS*POS_W  left/top edge per ball; ball i in bits [i*POS_W +: POS_W].
REQ-014 running  out  1  high in RUN or UPDATE.
REQ-015 game_over  out  1  high in OVER.
REQ-016 currentScore, highScore  out  SCORE_W.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, UPDATE, OVER; reset enters IDLE.
REQ-018 IDLE/OVER + start: load initial state, clear currentScore, tick counter, and speed; enter RUN next cycle.
REQ-019 Init per ball i: x = INIT_X + 2*i*BALL_SIZE, y = INIT_Y, x_dir = ~i[0] (1 = right), y_dir = 1 (1 = down).
REQ-020 start in RUN/UPDATE SHALL be ignored.
REQ-021 In RUN the tick counter counts 0..TICK_DIV-1; at TICK_DIV-1 it wraps to 0, the FSM enters UPDATE with index 0.
REQ-022 UPDATE processes one ball per cycle, index 0..NUM_BALLS-1; ball_x/ball_y of ball k change only in its cycle.
REQ-023 Movement per axis: next = pos +/- speed, computed in POS_W+1 bits; result <0 clamps to 0; result > limit (SCR_W-BALL_SIZE or SCR_H-BALL_SIZE) clamps to limit.
REQ-024 The axis direction SHALL invert when next equals 0 or limit after clamping.
REQ-025 Collision: ball (next position) overlaps bar iff x < bar_right, x+BALL_SIZE > bar_left, y < bar_bottom, y+BALL_SIZE > bar_top.
REQ-026 Any collision SHALL set a hit flag; the colliding ball's position still updates.
REQ-027 After the last ball: hit set -> OVER; else -> RUN. Remaining balls in the same pass are still updated.
REQ-028 Entering OVER: highScore = max(highScore, currentScore), same cycle.
REQ-029 Score: a tick counter (of movement ticks) counts to SCORE_TICKS-1, then currentScore increments, saturating at all-ones.
REQ-030 OVER freezes positions, scores, and counters until start.
REQ-031 A wall bounce and a collision in the same update: both apply; game over takes priority for state.

Reset
REQ-032 reset SHALL have priority over every input, including mid-UPDATE.
REQ-033 On reset: state IDLE; ball positions = init values; counters 0; currentScore = 0; highScore = 0; running = 0; game_over = 0.
REQ-034 start never clears highScore; only reset does.

Configuration
REQ-035 With BALL_ENGINE_SPEEDUP_EN defined, each currentScore increment SHALL add 1 to both axis speeds, saturating at MAX_SPD; start restores SPD_X/SPD_Y.
REQ-036 Without BALL_ENGINE_SPEEDUP_EN, speeds SHALL stay SPD_X/SPD_Y and no speed logic is synthesised.

Verification
REQ-037 Reset then start, TICK_DIV=4, bar off-field -> running=1 after 1 cycle; ball 0 at (242,94) after first pass.
REQ-038 Ball 0 forced near right wall at x=622, x_dir=1, SPD_X=2 -> x clamps to 624, x_dir flips to 0.
REQ-039 Bar box (240,300)-(400,320) on ball 0 path -> OVER after the UPDATE pass; game_over=1; highScore = currentScore.
REQ-040 SCORE_TICKS=3, 9 ticks, macro defined -> currentScore=3, speeds (5,7); macro undefined -> speeds (2,4).
REQ-041 Reset asserted during UPDATE index 1 -> next cycle IDLE, all outputs at reset values, highScore=0.
REQ-042 Start in OVER with highScore=5 -> currentScore=0, highScore=5, positions at init.
